sa_scheduler: RTL and testbench

SA_SCHEDULER -- requirements
Module: sa_scheduler

---
 rtl/sa_pkg.sv | 20 ++
 rtl/sa_skew.sv | 33 +++
 rtl/sa_scheduler.sv | 116 +++++++++++
 tb/tb_sa_scheduler.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// Shared types and default dimensions for the systolic-array operand scheduler.
`default_nettype none

package sa_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } sa_state_t;

  localparam int SA_N    = 4;
  localparam int SA_KMAX = 16;
  localparam int SA_DW   = 8;

endpackage

`default_nettype wire

// File: rtl/sa_skew.sv
// Triangular delay line: lane i presents its captured operand i+1 cycles later.
`default_nettype none

module sa_skew #(
  parameter int N  = 4,
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  input  logic [N*DW-1:0] i_data,
  output logic [N*DW-1:0] o_data
);

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    logic [DW-1:0] r_pipe [gi+1];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int s = 0; s <= gi; s++) r_pipe[s] <= '0;
      end else begin
        // Invalid capture cycles inject zeros so the array sees zero products.
        r_pipe[0] <= i_valid ? i_data[gi*DW +: DW] : '0;
        for (int s = 1; s <= gi; s++) r_pipe[s] <= r_pipe[s-1];
      end
    end

    assign o_data[gi*DW +: DW] = r_pipe[gi];
  end

endmodule

`default_nettype wire

// File: rtl/sa_scheduler.sv
// Sequences one NxN x NxK product: clears the MAC array, streams k operands
// through skew lines, drains the wavefront, then pulses done.
`default_nettype none

module sa_scheduler
  import sa_pkg::*;
#(
  parameter int N    = SA_N,
  parameter int KMAX = SA_KMAX,
  parameter int DW   = SA_DW,
  parameter int AW   = $clog2(KMAX)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [AW:0]     k_len,
  output logic            busy,
  output logic            done,
  output logic            mem_rd_en,
  output logic [AW-1:0]   mem_rd_addr,
  input  logic [N*DW-1:0] a_mem_data,
  input  logic [N*DW-1:0] b_mem_data,
  output logic [N*DW-1:0] a_edge,
  output logic [N*DW-1:0] b_edge,
  output logic            arr_clr_n
);

  localparam int             CW           = $clog2(KMAX + 2*N) + 1;
  localparam logic [CW-1:0]  C_DRAIN_LAST = CW'(2*N - 1);
  localparam logic [AW:0]    C_KMAX       = (AW+1)'(KMAX);

  sa_state_t     r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [AW:0]   r_k;
  logic [AW:0]   w_k_sat;
  logic [CW-1:0] w_k_last;
  logic          r_rd_vld;
  logic          r_clr_n;

  assign w_k_sat  = (k_len > C_KMAX) ? C_KMAX : k_len;
  assign w_k_last = CW'(r_k) - CW'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        w_cnt_nxt   = '0;
        w_state_nxt = (r_k == '0) ? S_DRAIN : S_FEED;
      end
      S_FEED: begin
        if (r_cnt == w_k_last) begin
          w_state_nxt = S_DRAIN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_DRAIN: begin
        if (r_cnt == C_DRAIN_LAST) begin
          w_state_nxt = S_DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_k      <= '0;
      r_rd_vld <= 1'b0;
      r_clr_n  <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      if (r_state == S_IDLE && start) r_k <= w_k_sat;
      // Read data returns one cycle after the strobe.
      r_rd_vld <= (r_state == S_FEED);
      r_clr_n  <= (w_state_nxt != S_CLEAR);
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign mem_rd_en   = (r_state == S_FEED);
  assign mem_rd_addr = r_cnt[AW-1:0];
  assign arr_clr_n   = r_clr_n;

  sa_skew #(.N(N), .DW(DW)) u_skew_a (
    .clk     (clk),
    .rst     (rst),
    .i_valid (r_rd_vld),
    .i_data  (a_mem_data),
    .o_data  (a_edge)
  );

  sa_skew #(.N(N), .DW(DW)) u_skew_b (
    .clk     (clk),
    .rst     (rst),
    .i_valid (r_rd_vld),
    .i_data  (b_mem_data),
    .o_data  (b_edge)
  );

endmodule

`default_nettype wire

// File: tb/tb_sa_scheduler.sv
// Scoreboard bench: operand buffers and an output-stationary MAC array model
// surround the scheduler; results are compared with a plain matrix product.
`default_nettype none

module tb_sa_scheduler;

  localparam int N    = 4;
  localparam int KMAX = 16;
  localparam int DW   = 8;
  localparam int AW   = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [AW:0]     k_len;
  logic            busy, done, mem_rd_en, arr_clr_n;
  logic [AW-1:0]   mem_rd_addr;
  logic [N*DW-1:0] a_mem_data, b_mem_data, a_edge, b_edge;

  sa_scheduler #(.N(N), .KMAX(KMAX), .DW(DW), .AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .k_len       (k_len),
    .busy        (busy),
    .done        (done),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .a_mem_data  (a_mem_data),
    .b_mem_data  (b_mem_data),
    .a_edge      (a_edge),
    .b_edge      (b_edge),
    .arr_clr_n   (arr_clr_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Operand buffers: garbage is returned whenever no read was issued.
  logic signed [DW-1:0] ma [N][KMAX];
  logic signed [DW-1:0] mb [KMAX][N];
  logic [N*DW-1:0] ta, tb_d;
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      ta[i*DW +: DW]   = mem_rd_en ? ma[i][mem_rd_addr] : DW'($urandom);
      tb_d[i*DW +: DW] = mem_rd_en ? mb[mem_rd_addr][i] : DW'($urandom);
    end
    a_mem_data <= ta;
    b_mem_data <= tb_d;
  end

  // Output-stationary MAC array: A flows east, B flows south, one hop per cycle.
  logic signed [DW-1:0] pa [N][N];
  logic signed [DW-1:0] pb [N][N];
  logic signed [31:0]   acc [N][N];
  logic signed [DW-1:0] ain, bin;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          pa[i][j] <= '0; pb[i][j] <= '0; acc[i][j] <= '0;
        end
    end else begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          if (j == 0) ain = a_edge[i*DW +: DW]; else ain = pa[i][j-1];
          if (i == 0) bin = b_edge[j*DW +: DW]; else bin = pb[i-1][j];
          pa[i][j]  <= ain;
          pb[i][j]  <= bin;
          acc[i][j] <= !arr_clr_n ? 32'sd0 : acc[i][j] + ain * bin;
        end
    end
  end

  // Reference model state: run accepted at cycle m_acc, finishes at m_end.
  int m_acc = -1000;
  int m_end = -1000;
  int ref_c [N][N];
  int q_rd_cyc[$], q_rd_addr[$], q_clr[$], q_done[$];
  bit ident_mode = 1'b0;

  task automatic accept(input int kl);
    int k;
    k = (kl > KMAX) ? KMAX : kl;
    m_acc = cyc;
    m_end = cyc + k + 2*N + 2;
    q_clr.push_back(cyc + 1);
    for (int a = 0; a < k; a++) begin
      q_rd_cyc.push_back(cyc + 2 + a);
      q_rd_addr.push_back(a);
    end
    q_done.push_back(m_end);
    for (int i = 0; i < N; i++)
      for (int kk = 0; kk < KMAX; kk++) begin
        ma[i][kk] = ident_mode ? DW'(i == kk) : DW'($urandom);
        mb[kk][i] = ident_mode ? DW'(4*kk + i + 1) : DW'($urandom);
      end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ref_c[i][j] = 0;
        for (int kk = 0; kk < k; kk++) ref_c[i][j] += int'(ma[i][kk]) * int'(mb[kk][j]);
      end
  endtask

  task automatic step(input bit s, input int kl);
    @(posedge clk); #1;
    start = s;
    k_len = kl[AW:0];
    if (s && rst && cyc > m_end) accept(kl);
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (cyc <= m_end + 1 && guard < 200) begin
      step(1'b0, 0);
      guard++;
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents an event.
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rd_en", mem_rd_en, 0);
      chk("rst_rd_addr", mem_rd_addr, 0);
      chk("rst_a_edge", a_edge, 0);
      chk("rst_b_edge", b_edge, 0);
      chk("rst_clr_n", arr_clr_n, 1);
    end else begin
      chk("busy", busy, (cyc > m_acc && cyc <= m_end));
      if (mem_rd_en) begin
        if (q_rd_cyc.size() == 0) chk("unexpected_read", cyc, -1);
        else begin
          chk("read_cycle", cyc, q_rd_cyc.pop_front());
          chk("read_addr", mem_rd_addr, q_rd_addr.pop_front());
        end
      end else if (q_rd_cyc.size() > 0 && q_rd_cyc[0] <= cyc) begin
        chk("missing_read", -1, q_rd_cyc.pop_front());
        void'(q_rd_addr.pop_front());
      end
      if (!arr_clr_n) begin
        if (q_clr.size() == 0) chk("unexpected_clear", cyc, -1);
        else chk("clear_cycle", cyc, q_clr.pop_front());
      end else if (q_clr.size() > 0 && q_clr[0] <= cyc) begin
        chk("missing_clear", -1, q_clr.pop_front());
      end
      if (done) begin
        if (q_done.size() == 0) chk("unexpected_done", cyc, -1);
        else begin
          chk("done_cycle", cyc, q_done.pop_front());
          chk("reads_left_at_done", q_rd_cyc.size(), 0);
          for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
              chk($sformatf("acc[%0d][%0d]", i, j), acc[i][j], ref_c[i][j]);
        end
      end else if (q_done.size() > 0 && q_done[0] <= cyc) begin
        chk("missing_done", -1, q_done.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; start = 1'b0; k_len = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    step(1'b0, 0);

    // Identity A with ramp B: accumulators become 4i+j+1.
    ident_mode = 1'b1;
    step(1'b1, 4); wait_idle();
    ident_mode = 1'b0;

    step(1'b1, 4);  wait_idle();
    step(1'b1, 0);  wait_idle();
    step(1'b1, 20); wait_idle();
    step(1'b1, 16); wait_idle();

    // Abort in the fourth cycle of a run, then restart.
    step(1'b1, 6);
    repeat (3) step(1'b0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    start = 1'b0;
    q_rd_cyc.delete(); q_rd_addr.delete(); q_clr.delete(); q_done.delete();
    m_acc = -1000; m_end = -1000;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    step(1'b1, 3); wait_idle();

    // Start held high: back-to-back runs with one idle gap.
    repeat (40) step(1'b1, 1);
    wait_idle();

    for (int n = 0; n < 1500; n++)
      step(($urandom % 4) == 0, int'($urandom % 32));
    wait_idle();
    repeat (3) step(1'b0, 0);

    chk("queues_empty", q_rd_cyc.size() + q_clr.size() + q_done.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
